// File: rtl/victim_writeback_buffer_if.sv
// Bus bundle between the victim cache, the write-back buffer and physical memory.
// The slave modport is the buffer's view; master is the surrounding environment.
interface victim_writeback_buffer_if;
   logic         vc_read;
   logic         vc_write;
   logic [15:0]  vc_address;
   logic [127:0] vc_wdata;
   logic [127:0] vc_rdata;
   logic         vc_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   modport slave (
      input  vc_read, vc_write, vc_address, vc_wdata, pmem_rdata, pmem_resp,
      output vc_rdata, vc_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport master (
      output vc_read, vc_write, vc_address, vc_wdata, pmem_rdata, pmem_resp,
      input  vc_rdata, vc_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/victim_writeback_buffer.sv
// Write-back buffer: absorbs evicted dirty lines in a small FIFO, forwards read hits,
// and drains entries to memory in insertion order whenever the upstream side is quiet.
module victim_writeback_buffer #(
   parameter int unsigned DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   victim_writeback_buffer_if.slave  bus,
   output logic                      empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {StIdle, StResp, StRead, StDrain} state_e;

   state_e              state_q, state_d;
   logic [PtrW-1:0]     head_q, tail_q;
   logic [CntW-1:0]     count_q;
   logic [DEPTH-1:0]    valid_q;
   logic [11:0]         addr_q [DEPTH];
   logic [127:0]        data_q [DEPTH];
   logic [127:0]        rdata_q;

   logic [11:0]         line_addr;
   logic                hit;
   logic [PtrW-1:0]     hit_idx;
   logic                full;
   logic                push, overwrite, pop, load_hit, load_mem;
   logic                unused_addr_bits;

   assign line_addr        = bus.vc_address[15:4];
   assign unused_addr_bits = ^bus.vc_address[3:0];
   assign full             = (count_q == CntW'(DEPTH));

   // Writes coalesce, so at most one valid entry can match.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && addr_q[i] == line_addr) begin
            hit     = 1'b1;
            hit_idx = PtrW'(i);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      push      = 1'b0;
      overwrite = 1'b0;
      pop       = 1'b0;
      load_hit  = 1'b0;
      load_mem  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.vc_write) begin
               if (hit) begin
                  overwrite = 1'b1;
                  state_d   = StResp;
               end else if (!full) begin
                  push    = 1'b1;
                  state_d = StResp;
               end else begin
                  state_d = StDrain;
               end
            end else if (bus.vc_read) begin
               if (hit) begin
                  load_hit = 1'b1;
                  state_d  = StResp;
               end else begin
                  state_d = StRead;
               end
            end else if (count_q != '0) begin
               state_d = StDrain;
            end
         end
         StResp: state_d = StIdle;
         StRead: begin
            if (bus.pmem_resp) begin
               load_mem = 1'b1;
               state_d  = StResp;
            end
         end
         StDrain: begin
            if (bus.pmem_resp) begin
               pop     = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.pmem_address = '0;
      bus.pmem_wdata   = '0;
      if (state_q == StRead) begin
         bus.pmem_address = {line_addr, 4'b0};
      end else if (state_q == StDrain) begin
         bus.pmem_address = {addr_q[head_q], 4'b0};
         bus.pmem_wdata   = data_q[head_q];
      end
   end

   assign bus.pmem_read  = (state_q == StRead);
   assign bus.pmem_write = (state_q == StDrain);
   assign bus.vc_resp    = (state_q == StResp);
   assign bus.vc_rdata   = rdata_q;
   assign empty          = (count_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (overwrite) begin
            data_q[hit_idx] <= bus.vc_wdata;
         end
         if (push) begin
            valid_q[tail_q] <= 1'b1;
            addr_q[tail_q]  <= line_addr;
            data_q[tail_q]  <= bus.vc_wdata;
            tail_q          <= tail_q + PtrW'(1);
            count_q         <= count_q + CntW'(1);
         end else if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + PtrW'(1);
            count_q         <= count_q - CntW'(1);
         end
         if (load_hit) begin
            rdata_q <= data_q[hit_idx];
         end else if (load_mem) begin
            rdata_q <= bus.pmem_rdata;
         end
      end
   end

endmodule

// File: doc/victim_writeback_buffer.md
Name: victim_writeback_buffer

Overview:
- Write-back buffer between the victim cache (upstream master) and physical memory (downstream slave).
- Absorbs dirty lines evicted by the victim cache into a small FIFO so the victim cache gets a fast response, then drains them to memory when the memory port is idle.
- Read requests that hit a buffered line are forwarded from the buffer.
- Read requests that miss go straight to memory.

Parameters:
- DEPTH, 2, number of 128-bit line entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- vc_read  input  1  victim cache read request; held high until vc_resp.
- vc_write  input  1  victim cache write (eviction) request; held high until vc_resp.
- vc_address  input  16  byte address; bits [3:0] are ignored.
- vc_wdata  input  128  line to buffer.
- vc_rdata  output  128  line returned on a read; valid while vc_resp=1.
- vc_resp  output  1  one-cycle completion pulse.
- pmem_read  output  1  memory read request.
- pmem_write  output  1  memory write request.
- pmem_address  output  16  line-aligned address, {line_addr, 4'b0}.
- pmem_wdata  output  128  line being written.
- pmem_rdata  input  128  memory read data; sampled when pmem_resp=1.
- pmem_resp  input  1  memory completion pulse.
- empty  output  1  high when the buffer holds no entries.

Behaviour:
- Storage: DEPTH entries, each holding {valid, line_addr[11:0], data[127:0]}.
- FIFO control: head pointer, tail pointer and count, each log2(DEPTH)-bit (count is one bit wider). Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Address match: vc_address[15:4] compared against every valid entry. At most one entry can match, because writes coalesce.
- Reset: state=IDLE; all valid bits, count, head and tail cleared. All outputs 0 at the following edge, except empty=1. Buffered data is discarded, including reset in the middle of a memory transaction.
- FSM states: IDLE, RESP, READ, DRAIN.
- IDLE priority order is fixed (first applicable wins):
  1. vc_write with a match: overwrite that entry's data in place (FIFO order and count unchanged) -> RESP.
  2. vc_write, no match, count<DEPTH: write the entry at tail, tail+1, count+1 -> RESP.
  3. vc_write, no match, count==DEPTH: -> DRAIN. The write stays pending and is re-evaluated in IDLE after the drain completes.
  4. vc_read with a match: register the entry data into vc_rdata -> RESP. No memory access.
  5. vc_read, no match: -> READ.
  6. No request and count>0: -> DRAIN.
  7. Otherwise stay in IDLE.
- Upstream latency: a request first seen in IDLE in cycle N (buffer hit or accepted write) gets vc_resp=1 in cycle N+1.
- READ:
  - pmem_read=1; pmem_address={vc_address[15:4],4'b0}.
  - On pmem_resp: capture pmem_rdata into vc_rdata -> RESP.
- DRAIN:
  - pmem_write=1; pmem_address and pmem_wdata come from the head entry.
  - On pmem_resp: clear the head valid bit, head+1, count-1 -> IDLE.
- RESP:
  - vc_resp=1 for exactly one cycle; vc_rdata stays stable in this cycle.
  - vc_read and vc_write are ignored in this cycle.
  - Always -> IDLE.
- Memory handshake:
  - pmem_read/pmem_write, pmem_address and pmem_wdata are held stable from assertion until the cycle pmem_resp is sampled.
  - They deassert in the cycle after pmem_resp.
  - A memory transaction is never abandoned except by rst.
  - pmem_read and pmem_write are never both high.
- Upstream requests arriving during READ or DRAIN wait; they are evaluated on return to IDLE.
- Correctness: a read miss bypasses buffered lines safely, because no buffered entry exists for that line address. Writes are never accepted during DRAIN, so the head entry cannot change while it is being written to memory.
- empty = (count==0). It is driven from registered state, so it updates the cycle after a push or pop.
- vc_rdata holds its last value outside RESP.
- Drain order is strictly FIFO by first insertion. Coalescing does not reorder entries.

Test Plan:
- Forwarding: write 0x1230 with data A; then read 0x123C -> vc_resp in the cycle after each request; read returns vc_rdata=A; pmem_read never asserted.
- Full stall (DEPTH=2): write 0x1000=A, then 0x2000=B, then 0x3000=C with no idle gap.
  - C triggers a drain: pmem_write to 0x1000 with wdata=A.
  - After pmem_resp, C is accepted and its vc_resp follows.
  - Buffer then holds B, C in that order.
- Coalesce: write 0x1000=A, then 0x1008=B -> count stays 1; the eventual drain issues exactly one pmem_write to 0x1000 with wdata=B.
- Read miss priority: buffer holds 0x1000, then read 0x4000.
  - pmem_read to 0x4000 is issued before any drain.
  - Memory returns D; vc_rdata=D with vc_resp; the drain of 0x1000 follows.
- Idle drain: two buffered lines and no requests -> two pmem_writes in insertion order; empty rises the cycle after the second pmem_resp.
- Reset mid-drain: assert rst while pmem_write=1 -> next cycle pmem_write=0, empty=1, vc_resp=0; a following read of a previously buffered address goes to memory.
